des_round_ctrl: RTL
===================

Name: des_round_ctrl

Overview:
- Sequencer for the iterative DES Feistel round datapath: expansion, key mix, S-boxes, P permutation and L/R swap.
- Accepts one block request per valid/ready handshake and issues the load strobe.
- Steps the datapath through 16 rounds and drives the key-schedule rotate amount and direction for encrypt or decrypt.
- Raises a result-valid handshake when the block is done. Sits between the top-level cipher FSM and the round/key-schedule registers.

Parameters:
- F_LATENCY, 1, cycles the f-function needs per round (1..4); round_en pulses once every F_LATENCY cycles.
- ROUNDS, 16, round count; fixed at 16 for DES, exposed for test only.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  requester has a block ready
- in_ready  out  1  controller can accept a block
- in_decrypt  in  1  mode, sampled at in handshake; 1 = decrypt
- round_load  out  1  one-cycle pulse: datapath loads L/R from IP(block) and C/D from PC1(key)
- round_en  out  1  one-cycle pulse: datapath registers new L/R and new C/D
- round_idx  out  4  current round, 0..15
- key_shift  out  2  C/D rotate amount for the current round (0, 1 or 2)
- key_dir  out  1  0 = rotate left (encrypt), 1 = rotate right (decrypt)
- last_round  out  1  high while round_idx==ROUNDS-1; datapath suppresses the L/R swap
- out_valid  out  1  result in datapath output registers is valid
- out_ready  in  1  consumer accepts the result
- busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, LOAD, ROUND, DONE.
- Reset (rst high at a clk edge, from any state, including mid-round): state=IDLE, round_idx=0, sub-counter=0, mode=0.
  - Resulting outputs: in_ready=1, round_load=0, round_en=0, key_shift=0, key_dir=0, last_round=0, out_valid=0, busy=0.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: latch in_decrypt into mode, go to LOAD. Otherwise stay.
- LOAD:
  - Exactly one cycle; round_load=1.
  - Clear round_idx and sub-counter; go to ROUND.
- ROUND:
  - Sub-counter counts 0..F_LATENCY-1. round_en=1 in the cycle the sub-counter equals F_LATENCY-1.
  - On that cycle's edge, the sub-counter clears and round_idx increments.
  - The round_en with round_idx==15 moves the state to DONE, and round_idx wraps to 0.
- DONE:
  - out_valid=1, held until out_ready.
  - out_valid&&out_ready goes to IDLE. The next accept is possible no earlier than the following cycle; in_ready=0 in DONE.
- Outputs in non-ROUND states: key_shift=0, key_dir=mode, last_round=0, round_en=0.
- Key schedule, combinational from round_idx and mode, stable throughout ROUND.
  - Encrypt (left rotate) per round 0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28).
  - Decrypt (right rotate) per round 0..15: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 27).
- Latency (handshake at edge T):
  - round_load in the cycle after T.
  - First round_en F_LATENCY cycles after LOAD.
  - out_valid asserts 2+16*F_LATENCY cycles after T; 18 cycles for F_LATENCY=1.
- Other rules:
  - in_valid while busy is ignored; no request is queued.
  - in_decrypt changes after the handshake have no effect.
  - out_ready while not in DONE is ignored.
  - in_valid and out_ready both high in DONE: only the output completes.

Decomposition:
- des_pkg holds: state enum, DES_ROUNDS=16 constant, 16-entry encrypt shift table.
  - The decrypt table is derived: entry 0 forced to 0, else the encrypt entry.
- One sub-module, des_shift_sched: combinational (round_idx, mode) -> (key_shift, key_dir). Reused by a future pipelined key scheduler.

Test Plan:
- Reset then idle: rst held 3 cycles, then released -> in_ready=1, out_valid=0, busy=0, round_en never pulses over 20 idle cycles.
- Encrypt, F_LATENCY=1: in_valid=1, in_decrypt=0 at cycle 0.
  - round_load at cycle 1; round_en at cycles 2..17 with round_idx 0..15.
  - key_shift sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, key_dir=0; last_round only at cycle 17.
  - out_valid at cycle 18.
- Decrypt schedule: in_decrypt=1 -> key_dir=1, key_shift sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, shift sum 27.
  - Known-answer check with the full datapath: key 133457799BBCDFF1 encrypts 0123456789ABCDEF to 85E813540F0AB405, and decrypts back.
- Backpressure and overlap: hold out_ready=0 for 10 cycles after out_valid -> out_valid stays 1, in_ready=0 and a second in_valid is ignored.
  - Raise out_ready -> IDLE next cycle, then the second block is accepted.
- F_LATENCY=3: round_en spacing exactly 3 cycles; out_valid 50 cycles after the handshake.
- Reset mid-operation: assert rst when round_idx=7 -> next cycle IDLE, round_idx=0, no further round_en, out_valid=0. A new request then completes normally.

Source files
------------

// File: rtl/des_pkg.sv
// Shared types and constants for the iterative DES round controller.
package des_pkg;

    localparam int unsigned DES_ROUNDS = 16;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned SHIFT_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Encrypt C/D left-rotate amount per round; entry i lives at bits [2*i +: 2].
    localparam logic [2*DES_ROUNDS-1:0] ENC_SHIFT_TABLE = {
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,   // rounds 15..8
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1    // rounds 7..0
    };

    // Left-rotate amount for an encrypt round.
    function automatic logic [SHIFT_W-1:0] enc_shift(input logic [IDX_W-1:0] idx);
        return ENC_SHIFT_TABLE[{idx, 1'b0} +: SHIFT_W];
    endfunction

    // Right-rotate amount for a decrypt round: PC1(key) already equals K16's C/D,
    // so round 0 needs no rotation; later rounds undo the encrypt rotations.
    function automatic logic [SHIFT_W-1:0] dec_shift(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(0)) ? SHIFT_W'(0) : enc_shift(idx);
    endfunction

endpackage

// File: rtl/des_shift_sched.sv
// Key-schedule rotate amount and direction for a given round and mode.
module des_shift_sched
    import des_pkg::*;
(
    input  logic [IDX_W-1:0]   round_idx,
    input  logic               mode,
    output logic [SHIFT_W-1:0] key_shift,
    output logic               key_dir
);

    // Select the table for the current direction.
    always_comb begin
        key_dir   = mode;
        key_shift = mode ? dec_shift(round_idx) : enc_shift(round_idx);
    end

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencer for the iterative DES Feistel round datapath.
module des_round_ctrl
    import des_pkg::*;
#(
    parameter int unsigned F_LATENCY = 1,
    parameter int unsigned ROUNDS    = DES_ROUNDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_decrypt,
    output logic               round_load,
    output logic               round_en,
    output logic [IDX_W-1:0]   round_idx,
    output logic [SHIFT_W-1:0] key_shift,
    output logic               key_dir,
    output logic               last_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    localparam int unsigned SUB_W = 2;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(F_LATENCY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUNDS - 1);

    state_e             state, state_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic [SUB_W-1:0]   sub_cnt, sub_nxt;
    logic               mode, mode_nxt;
    logic [SHIFT_W-1:0] sched_shift;
    logic               sched_dir;

    des_shift_sched u_sched (
        .round_idx (round_idx),
        .mode      (mode),
        .key_shift (sched_shift),
        .key_dir   (sched_dir)
    );

    // State, round counter, f-function sub-counter and latched mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            round_idx <= '0;
            sub_cnt   <= '0;
            mode      <= 1'b0;
        end else begin
            state     <= state_nxt;
            round_idx <= idx_nxt;
            sub_cnt   <= sub_nxt;
            mode      <= mode_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = round_idx;
        sub_nxt    = sub_cnt;
        mode_nxt   = mode;
        in_ready   = 1'b0;
        round_load = 1'b0;
        round_en   = 1'b0;
        key_shift  = '0;
        key_dir    = sched_dir;
        last_round = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;

        unique case (state)
            ST_IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    mode_nxt  = in_decrypt;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                round_load = 1'b1;
                idx_nxt    = '0;
                sub_nxt    = '0;
                state_nxt  = ST_ROUND;
            end
            ST_ROUND: begin
                key_shift  = sched_shift;
                last_round = (round_idx == IDX_LAST);
                if (sub_cnt == SUB_LAST) begin
                    round_en = 1'b1;
                    sub_nxt  = '0;
                    if (round_idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt = round_idx + IDX_W'(1);
                    end
                end else begin
                    sub_nxt = sub_cnt + SUB_W'(1);
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
